// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline front end: NOP encoding, control-bundle
// layout and the redirect FSM state type.
package pipeline_pkg;

  localparam int CTRL_W = 8;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Bit positions inside the decoded control bundle.
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_ALU_SRC    = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/pipeline_front_ctrl_if.sv
// Hazard-control, fetch/decode and counter signals between the pipeline and
// the front-end controller.
interface pipeline_front_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);

  logic              PCWrite;
  logic              IF_ID_Write;
  logic              ID_EX_mux_out;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   IF_ID_pc;
  logic [31:0]       IF_ID_instr;
  logic              IF_ID_valid;
  logic [CTRL_W-1:0] ID_EX_ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output PCWrite, IF_ID_Write, ID_EX_mux_out, branch_taken, branch_target,
           instr_in, ctrl_in,
    input  pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid, ID_EX_ctrl,
           stall_count, flush_count
  );

  modport slave (
    input  PCWrite, IF_ID_Write, ID_EX_mux_out, branch_taken, branch_target,
           instr_in, ctrl_in,
    output pc_out, IF_ID_pc, IF_ID_instr, IF_ID_valid, ID_EX_ctrl,
           stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_front_ctrl_chk.sv
// Protocol checks on the hazard-unit controls seen by the front end.
module pipeline_front_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic pc_write,
  input logic if_id_write
);

  // Advancing the PC while freezing IF/ID would drop an instruction.
  pc_write_without_if_id_write: assert property (
    @(posedge clk) disable iff (reset) !(pc_write && !if_id_write)
  );

endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count qualifying edges until the top value is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_front_ctrl.sv
// Front-end control: PC, IF/ID register and ID/EX control field, driven by
// hazard-unit stall/bubble requests and EX-stage branch redirects.
module pipeline_front_ctrl #(
  parameter int              XLEN         = 64,
  parameter int              CTRL_W       = 8,
  parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}},
  parameter int              FLUSH_CYCLES = 1,
  parameter int              CNT_W        = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_front_ctrl_if.slave bus
);

  import pipeline_pkg::*;

  localparam logic [1:0]      FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

  fsm_state_t        state_r;
  fsm_state_t        state_nxt_s;
  logic [1:0]        fcnt_r;
  logic [1:0]        fcnt_nxt_s;
  logic              flush_s;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   if_id_pc_r;
  logic [31:0]       if_id_instr_r;
  logic              if_id_valid_r;
  logic [CTRL_W-1:0] id_ex_ctrl_r;

  // Redirect FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
      fcnt_r  <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
    end
  end

  // The redirect edge is the first invalid decode cycle; FLUSH covers the
  // remaining ones and its last cycle (count zero) lets IF/ID load again.
  always_comb begin
    state_nxt_s = state_r;
    fcnt_nxt_s  = fcnt_r;
    flush_s     = 1'b0;
    if (bus.branch_taken) begin
      state_nxt_s = ST_FLUSH;
      fcnt_nxt_s  = FLUSH_INIT;
      flush_s     = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          state_nxt_s = ST_RUN;
        end
        ST_FLUSH: begin
          if (fcnt_r == 2'd0) begin
            state_nxt_s = ST_RUN;
          end else begin
            fcnt_nxt_s = fcnt_r - 2'd1;
            flush_s    = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          fcnt_nxt_s  = 2'd0;
        end
      endcase
    end
  end

  // Fetch PC: redirect beats stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (bus.branch_taken) begin
      pc_r <= bus.branch_target;
    end else if (bus.PCWrite) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  // IF/ID register: flush beats stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_pc_r    <= {XLEN{1'b0}};
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
    end else if (flush_s) begin
      if_id_pc_r    <= pc_r;
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
    end else if (bus.IF_ID_Write) begin
      if_id_pc_r    <= pc_r;
      if_id_instr_r <= bus.instr_in;
      if_id_valid_r <= 1'b1;
    end else begin
      if_id_pc_r    <= if_id_pc_r;
      if_id_instr_r <= if_id_instr_r;
      if_id_valid_r <= if_id_valid_r;
    end
  end

  // ID/EX control field: bubble on hazard request, redirect or empty decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_ctrl_r <= {CTRL_W{1'b0}};
    end else if (!bus.ID_EX_mux_out || bus.branch_taken || !if_id_valid_r) begin
      id_ex_ctrl_r <= {CTRL_W{1'b0}};
    end else begin
      id_ex_ctrl_r <= bus.ctrl_in;
    end
  end

  assign bus.pc_out      = pc_r;
  assign bus.IF_ID_pc    = if_id_pc_r;
  assign bus.IF_ID_instr = if_id_instr_r;
  assign bus.IF_ID_valid = if_id_valid_r;
  assign bus.ID_EX_ctrl  = id_ex_ctrl_r;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~bus.PCWrite),
    .count (bus.stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.branch_taken),
    .count (bus.flush_count)
  );

  pipeline_front_ctrl_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (bus.PCWrite),
    .if_id_write (bus.IF_ID_Write)
  );

endmodule

// File: tb/tb_pipeline_front_ctrl.sv
// Randomized bench for pipeline_front_ctrl against a cycle-level reference
// model; a narrow-counter instance shares the stimulus to reach saturation.
module tb_pipeline_front_ctrl;

  localparam int          FC   = 2;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          MAXW = 65535;
  localparam int          MAXS = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_front_ctrl_if #(.XLEN(64), .CTRL_W(8), .CNT_W(16)) pif ();
  pipeline_front_ctrl_if #(.XLEN(64), .CTRL_W(8), .CNT_W(4))  sif ();

  assign sif.PCWrite       = pif.PCWrite;
  assign sif.IF_ID_Write   = pif.IF_ID_Write;
  assign sif.ID_EX_mux_out = pif.ID_EX_mux_out;
  assign sif.branch_taken  = pif.branch_taken;
  assign sif.branch_target = pif.branch_target;
  assign sif.instr_in      = pif.instr_in;
  assign sif.ctrl_in       = pif.ctrl_in;

  pipeline_front_ctrl #(.XLEN(64), .CTRL_W(8), .RESET_PC(64'd0), .FLUSH_CYCLES(FC), .CNT_W(16))
    dut (.clk(clk), .reset(rst), .bus(pif.slave));

  pipeline_front_ctrl #(.XLEN(64), .CTRL_W(8), .RESET_PC(64'd0), .FLUSH_CYCLES(1), .CNT_W(4))
    dut_sat (.clk(clk), .reset(rst), .bus(sif.slave));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [7:0]  m_ctrl;
  int          m_flush_left, m_stall_n, m_flush_n;

  function automatic logic [15:0] sat_w(int n);
    return 16'((n > MAXW) ? MAXW : n);
  endfunction

  function automatic logic [3:0] sat_s(int n);
    return 4'((n > MAXS) ? MAXS : n);
  endfunction

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_instr = NOP; m_valid = 1'b0; m_ctrl = 8'h00;
    m_flush_left = 0; m_stall_n = 0; m_flush_n = 0;
  endtask

  task automatic set_defaults();
    pif.PCWrite = 1'b1; pif.IF_ID_Write = 1'b1; pif.ID_EX_mux_out = 1'b1;
    pif.branch_taken = 1'b0; pif.branch_target = 64'd0;
  endtask

  // One clock edge: advance the model with the inputs present at that edge.
  task automatic tick();
    logic flush_now;
    @(posedge clk);
    #1;
    flush_now = pif.branch_taken || (m_flush_left > 0);
    m_ctrl = (!pif.ID_EX_mux_out || pif.branch_taken || !m_valid) ? 8'h00 : pif.ctrl_in;
    if (flush_now) begin
      m_instr = NOP; m_valid = 1'b0; m_ifpc = m_pc;
    end else if (pif.IF_ID_Write) begin
      m_instr = pif.instr_in; m_valid = 1'b1; m_ifpc = m_pc;
    end
    if (pif.branch_taken) m_pc = pif.branch_target;
    else if (pif.PCWrite) m_pc = m_pc + 64'd4;
    m_flush_left = pif.branch_taken ? FC - 1 : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
    if (!pif.PCWrite) m_stall_n++;
    if (pif.branch_taken) m_flush_n++;
    pif.instr_in = $urandom();
    pif.ctrl_in = 8'($urandom_range(1, 255));
  endtask

  task automatic do_reset();
    set_defaults();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    pif.instr_in = 32'hDEAD_BEEF; pif.ctrl_in = 8'hA5;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (pif.pc_out !== 64'd0) begin n_err++; $display("FAIL reset pc_out: got %h want %h", pif.pc_out, 64'd0); end
    n_vec++; if (pif.IF_ID_pc !== 64'd0) begin n_err++; $display("FAIL reset IF_ID_pc: got %h want 0", pif.IF_ID_pc); end
    n_vec++; if (pif.IF_ID_instr !== NOP) begin n_err++; $display("FAIL reset IF_ID_instr: got %h want %h", pif.IF_ID_instr, NOP); end
    n_vec++; if (pif.IF_ID_valid !== 1'b0) begin n_err++; $display("FAIL reset IF_ID_valid: got %b want 0", pif.IF_ID_valid); end
    n_vec++; if (pif.ID_EX_ctrl !== 8'h00) begin n_err++; $display("FAIL reset ID_EX_ctrl: got %h want 00", pif.ID_EX_ctrl); end
    n_vec++; if (pif.stall_count !== 16'd0 || pif.flush_count !== 16'd0) begin n_err++; $display("FAIL reset counters: got %0d/%0d want 0/0", pif.stall_count, pif.flush_count); end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset();
    n_vec++; if (pif.IF_ID_valid !== 1'b0) begin n_err++; $display("FAIL free_run first valid: got %b want 0", pif.IF_ID_valid); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++; if (pif.pc_out !== 64'(4 * k)) begin n_err++; $display("FAIL free_run pc_out[%0d]: got %h want %h", k, pif.pc_out, 64'(4 * k)); end
      n_vec++; if (pif.IF_ID_pc !== 64'(4 * (k - 1))) begin n_err++; $display("FAIL free_run IF_ID_pc[%0d]: got %h want %h", k, pif.IF_ID_pc, 64'(4 * (k - 1))); end
      n_vec++; if (pif.IF_ID_valid !== 1'b1) begin n_err++; $display("FAIL free_run valid[%0d]: got %b want 1", k, pif.IF_ID_valid); end
      n_vec++; if (pif.IF_ID_instr !== m_instr || pif.ID_EX_ctrl !== m_ctrl) begin n_err++; $display("FAIL free_run instr/ctrl[%0d]: got %h/%h want %h/%h", k, pif.IF_ID_instr, pif.ID_EX_ctrl, m_instr, m_ctrl); end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] held;
    do_reset();
    tick(); tick();
    held = m_instr;
    pif.PCWrite = 1'b0; pif.IF_ID_Write = 1'b0; pif.ID_EX_mux_out = 1'b0;
    tick();
    n_vec++; if (pif.pc_out !== 64'h8) begin n_err++; $display("FAIL load_use pc_out: got %h want 8", pif.pc_out); end
    n_vec++; if (pif.IF_ID_instr !== held) begin n_err++; $display("FAIL load_use IF_ID_instr: got %h want %h", pif.IF_ID_instr, held); end
    n_vec++; if (pif.ID_EX_ctrl !== 8'h00) begin n_err++; $display("FAIL load_use ID_EX_ctrl: got %h want 00", pif.ID_EX_ctrl); end
    n_vec++; if (pif.stall_count !== 16'd1) begin n_err++; $display("FAIL load_use stall_count: got %0d want 1", pif.stall_count); end
    set_defaults();
    tick();
    n_vec++; if (pif.pc_out !== 64'hC || pif.ID_EX_ctrl !== m_ctrl) begin n_err++; $display("FAIL load_use resume: got %h/%h want c/%h", pif.pc_out, pif.ID_EX_ctrl, m_ctrl); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (8) tick();
    pif.branch_taken = 1'b1; pif.branch_target = 64'h100;
    tick();
    n_vec++; if (pif.pc_out !== 64'h100) begin n_err++; $display("FAIL branch pc_out: got %h want 100", pif.pc_out); end
    n_vec++; if (pif.IF_ID_valid !== 1'b0 || pif.ID_EX_ctrl !== 8'h00) begin n_err++; $display("FAIL branch flush1 valid/ctrl: got %b/%h want 0/00", pif.IF_ID_valid, pif.ID_EX_ctrl); end
    n_vec++; if (pif.flush_count !== 16'd1) begin n_err++; $display("FAIL branch flush_count: got %0d want 1", pif.flush_count); end
    set_defaults();
    tick();
    n_vec++; if (pif.pc_out !== 64'h104 || pif.IF_ID_valid !== 1'b0 || pif.ID_EX_ctrl !== 8'h00) begin n_err++; $display("FAIL branch flush2: got %h/%b/%h want 104/0/00", pif.pc_out, pif.IF_ID_valid, pif.ID_EX_ctrl); end
    tick();
    n_vec++; if (pif.IF_ID_valid !== 1'b1 || pif.IF_ID_pc !== 64'h104 || pif.ID_EX_ctrl !== 8'h00) begin n_err++; $display("FAIL branch refill: got %b/%h/%h want 1/104/00", pif.IF_ID_valid, pif.IF_ID_pc, pif.ID_EX_ctrl); end
    tick();
    n_vec++; if (pif.ID_EX_ctrl !== m_ctrl || pif.ID_EX_ctrl === 8'h00) begin n_err++; $display("FAIL branch ctrl resume: got %h want %h", pif.ID_EX_ctrl, m_ctrl); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    repeat (3) tick();
    pif.branch_taken = 1'b1; pif.branch_target = 64'h40;
    pif.PCWrite = 1'b0; pif.IF_ID_Write = 1'b0; pif.ID_EX_mux_out = 1'b0;
    tick();
    n_vec++; if (pif.pc_out !== 64'h40) begin n_err++; $display("FAIL branch_stall pc_out: got %h want 40", pif.pc_out); end
    n_vec++; if (pif.IF_ID_valid !== 1'b0 || pif.IF_ID_instr !== NOP || pif.IF_ID_pc !== 64'hC) begin n_err++; $display("FAIL branch_stall IF/ID: got %b/%h/%h want 0/%h/c", pif.IF_ID_valid, pif.IF_ID_instr, pif.IF_ID_pc, NOP); end
    n_vec++; if (pif.stall_count !== 16'd1 || pif.flush_count !== 16'd1) begin n_err++; $display("FAIL branch_stall counters: got %0d/%0d want 1/1", pif.stall_count, pif.flush_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    pif.branch_taken = 1'b1; pif.branch_target = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    set_defaults();
    tick();
    n_vec++; if (pif.pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap pc top: got %h want fffffffffffffffc", pif.pc_out); end
    tick();
    n_vec++; if (pif.pc_out !== 64'd0 || pif.IF_ID_pc !== 64'hFFFF_FFFF_FFFF_FFFC || pif.IF_ID_valid !== 1'b1) begin n_err++; $display("FAIL wrap to zero: got %h/%h/%b want 0/fffffffffffffffc/1", pif.pc_out, pif.IF_ID_pc, pif.IF_ID_valid); end
    tick();
    n_vec++; if (pif.pc_out !== 64'd4 || pif.stall_count !== 16'd0 || pif.flush_count !== 16'd1) begin n_err++; $display("FAIL wrap after: got %h/%0d/%0d want 4/0/1", pif.pc_out, pif.stall_count, pif.flush_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    pif.PCWrite = 1'b0;
    repeat (14) tick();
    n_vec++; if (sif.stall_count !== 4'hE || pif.stall_count !== 16'd14) begin n_err++; $display("FAIL sat pre stall: got %h/%0d want e/14", sif.stall_count, pif.stall_count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (sif.stall_count !== 4'hF) begin n_err++; $display("FAIL sat stall hold[%0d]: got %h want f", k, sif.stall_count); end
    end
    n_vec++; if (pif.stall_count !== 16'd17) begin n_err++; $display("FAIL sat wide stall: got %0d want 17", pif.stall_count); end
    set_defaults();
    pif.branch_taken = 1'b1;
    repeat (17) begin
      pif.branch_target = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
    end
    n_vec++; if (sif.flush_count !== 4'hF || pif.flush_count !== 16'd17) begin n_err++; $display("FAIL sat flush: got %h/%0d want f/17", sif.flush_count, pif.flush_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) tick();
    pif.branch_taken = 1'b1; pif.branch_target = 64'h200;
    tick();
    set_defaults();
    pif.PCWrite = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (pif.pc_out !== 64'd0 || pif.IF_ID_pc !== 64'd0 || pif.IF_ID_instr !== NOP) begin n_err++; $display("FAIL async_reset pc/IF_ID: got %h/%h/%h", pif.pc_out, pif.IF_ID_pc, pif.IF_ID_instr); end
    n_vec++; if (pif.IF_ID_valid !== 1'b0 || pif.ID_EX_ctrl !== 8'h00 || pif.stall_count !== 16'd0 || pif.flush_count !== 16'd0) begin n_err++; $display("FAIL async_reset rest: got %b/%h/%0d/%0d want 0/00/0/0", pif.IF_ID_valid, pif.ID_EX_ctrl, pif.stall_count, pif.flush_count); end
    model_reset();
    set_defaults();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    n_vec++; if (pif.pc_out !== 64'd4 || pif.IF_ID_valid !== 1'b1 || pif.IF_ID_pc !== 64'd0) begin n_err++; $display("FAIL async_reset restart: got %h/%b/%h want 4/1/0", pif.pc_out, pif.IF_ID_valid, pif.IF_ID_pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pif.PCWrite = ($urandom_range(0, 3) != 0);
      pif.IF_ID_Write = pif.PCWrite ? 1'b1 : 1'($urandom_range(0, 1));
      pif.ID_EX_mux_out = ($urandom_range(0, 4) != 0);
      pif.branch_taken = ($urandom_range(0, 6) == 0);
      pif.branch_target = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      n_vec++; if (pif.pc_out !== m_pc || pif.IF_ID_pc !== m_ifpc) begin n_err++; $display("FAIL random pc[%0d]: got %h/%h want %h/%h", i, pif.pc_out, pif.IF_ID_pc, m_pc, m_ifpc); end
      n_vec++; if (pif.IF_ID_instr !== m_instr || pif.IF_ID_valid !== m_valid) begin n_err++; $display("FAIL random IF_ID[%0d]: got %h/%b want %h/%b", i, pif.IF_ID_instr, pif.IF_ID_valid, m_instr, m_valid); end
      n_vec++; if (pif.ID_EX_ctrl !== m_ctrl) begin n_err++; $display("FAIL random ctrl[%0d]: got %h want %h", i, pif.ID_EX_ctrl, m_ctrl); end
      n_vec++; if (pif.stall_count !== sat_w(m_stall_n) || pif.flush_count !== sat_w(m_flush_n)) begin n_err++; $display("FAIL random counters[%0d]: got %0d/%0d want %0d/%0d", i, pif.stall_count, pif.flush_count, sat_w(m_stall_n), sat_w(m_flush_n)); end
      n_vec++; if (sif.stall_count !== sat_s(m_stall_n) || sif.flush_count !== sat_s(m_flush_n)) begin n_err++; $display("FAIL random narrow counters[%0d]: got %0d/%0d want %0d/%0d", i, sif.stall_count, sif.flush_count, sat_s(m_stall_n), sat_s(m_flush_n)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_defaults();
    pif.instr_in = 32'h0; pif.ctrl_in = 8'h0;
    test_reset();
    test_free_run();
    test_load_use();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_front_ctrl.md
Name: pipeline_front_ctrl

Overview:
- Consumer end of the hazard-control interface: applies PCWrite, IF_ID_Write and ID_EX_mux_out, plus branch redirects from EX, to the architectural front-end state.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control-field register.
- Sits between instruction memory, the hazard detection unit, the decoder and the ID/EX datapath register of the 5-stage RV64 pipeline.
- Provides saturating stall and flush performance counters.

Parameters:
- XLEN, 64, width of PC and branch target.
- CTRL_W, 8, width of the decoded control bundle (RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]).
- RESET_PC, 0, PC value after reset.
- FLUSH_CYCLES, 1, number of cycles IF/ID stays invalid after a redirect (range 1..3).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- PCWrite  in  1  from hazard unit; 0 holds PC
- IF_ID_Write  in  1  from hazard unit; 0 holds IF/ID
- ID_EX_mux_out  in  1  from hazard unit; 0 inserts bubble into ID/EX control
- branch_taken  in  1  EX-stage redirect request
- branch_target  in  XLEN  redirect address
- instr_in  in  32  instruction memory read data for pc_out
- ctrl_in  in  CTRL_W  decoder control bundle for IF_ID_instr
- pc_out  out  XLEN  current fetch PC
- IF_ID_pc  out  XLEN  PC of instruction in decode
- IF_ID_instr  out  32  instruction in decode
- IF_ID_valid  out  1  decode slot holds a real instruction
- ID_EX_ctrl  out  CTRL_W  registered control bundle for EX
- stall_count  out  CNT_W  cycles with PCWrite=0
- flush_count  out  CNT_W  redirects taken

Behaviour:
- Reset (async, immediate) values:
  - pc_out=RESET_PC
  - IF_ID_pc=0
  - IF_ID_instr=32'h00000013 (NOP)
  - IF_ID_valid=0
  - ID_EX_ctrl=0
  - both counters=0
  - FSM=RUN
  - flush counter=0
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on branch_taken.
  - FLUSH -> RUN after FLUSH_CYCLES cycles with no new branch_taken.
  - branch_taken while in FLUSH reloads the flush counter and redirects again.
- Per-edge priority for PC: branch_taken > PCWrite.
  - branch_taken=1: pc<=branch_target, regardless of PCWrite.
  - Else PCWrite=1: pc<=pc+4 (XLEN wrap-around, no trap).
  - Else hold.
- Priority for IF/ID: branch_taken or FSM=FLUSH > IF_ID_Write.
  - Flush: IF_ID_instr<=NOP, IF_ID_valid<=0, IF_ID_pc<=pc_out.
  - Else IF_ID_Write=1: IF_ID_instr<=instr_in, IF_ID_pc<=pc_out, IF_ID_valid<=1.
  - Else hold all three.
- ID_EX_ctrl:
  - Loads 0 if ID_EX_mux_out=0, branch_taken=1, or IF_ID_valid=0.
  - Otherwise loads ctrl_in.
- Latency: instr_in fetched at pc_out appears on IF_ID_instr one edge later; its control appears on ID_EX_ctrl one edge after that.
- Simultaneous stall and branch: branch wins. PC redirects, IF/ID flushed, ID/EX bubbled. The stall cycle is still counted.
- stall_count increments on every edge with PCWrite=0 and not in reset; saturates at all-ones.
- flush_count increments on every edge with branch_taken=1; saturates at all-ones.
- Reset asserted mid-stall or mid-flush returns everything to reset values on the next evaluation; no partial state survives.
- PCWrite=1 with IF_ID_Write=0 is illegal from the hazard unit. The block still obeys each signal independently, and an SVA assertion flags it.

Decomposition:
- Shared package pipeline_pkg: NOP_INSTR constant, CTRL_W, control-bundle bit-index constants, fsm state typedef.
- One sub-module, sat_counter (CNT_W, inc, clk, reset), instantiated twice for the performance counters.

Test Plan:
- Reset then 4 free-running cycles, RESET_PC=0 -> pc_out 0,4,8,12,16; IF_ID_valid=0 in the first cycle, then 1; IF_ID_pc lags pc_out by one cycle.
- Load-use stall at pc=8: drive PCWrite=IF_ID_Write=ID_EX_mux_out=0 for 1 cycle -> pc_out holds 8; IF_ID_instr unchanged; ID_EX_ctrl=0 for one cycle; stall_count=1.
- branch_taken with target 0x100 at pc=0x20, FLUSH_CYCLES=2 -> pc_out=0x100, then 0x104; IF_ID_valid=0 for 2 cycles; ID_EX_ctrl=0 for the bubble cycles; flush_count=1.
- branch_taken and PCWrite=0 in the same cycle, target 0x40 -> pc_out=0x40; IF/ID flushed; stall_count and flush_count both +1.
- pc=2^64-4 free-running -> pc_out wraps to 0; no other side effects.
- Force stall_count to 0xFFFE and stall 3 cycles -> counter reads 0xFFFF and holds. Assert reset mid-flush -> all outputs return to reset values asynchronously.
